// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator for raster-order pixel streams.
// Two line buffers hold rows r-1 and r-2; each window line is a 3-tap
// horizontal shift register. Outputs update one cycle after an accepted pixel.
module window_gen_3x3 #(
  parameter int IMG_WIDTH = 640,
  parameter int PIX_W     = 24
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [PIX_W-1:0] DIN,
  input  logic             DIN_VALID,
  input  logic             DIN_SOF,
  output logic [PIX_W-1:0] D02,
  output logic [PIX_W-1:0] D01,
  output logic [PIX_W-1:0] D00,
  output logic [PIX_W-1:0] D12,
  output logic [PIX_W-1:0] D11,
  output logic [PIX_W-1:0] D10,
  output logic [PIX_W-1:0] D22,
  output logic [PIX_W-1:0] D21,
  output logic [PIX_W-1:0] D20,
  output logic             WIN_VALID
);

  localparam int            CW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);

  logic [CW-1:0]    col, col_eff, col_nxt;
  logic [1:0]       row, row_eff, row_nxt;
  logic             accept;
  logic [PIX_W-1:0] tap1, tap2;

  // lb1 holds row r-1, lb2 holds row r-2, both indexed by column
  logic [PIX_W-1:0] lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] lb2 [IMG_WIDTH];

  // Effective position of the incoming pixel (SOF forces 0,0) and next counters
  always_comb begin
    accept  = DIN_VALID & RESET;
    col_eff = DIN_SOF ? '0 : col;
    row_eff = DIN_SOF ? 2'd0 : row;
    if (col_eff == LAST_COL) begin
      col_nxt = '0;
      row_nxt = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
    end else begin
      col_nxt = col_eff + 1'b1;
      row_nxt = row_eff;
    end
    tap1 = lb1[col_eff];
    tap2 = lb2[col_eff];
  end

  // Line buffers: the current pixel replaces row r-1, which cascades into row r-2
  always_ff @(posedge CLK) begin
    if (accept) begin
      lb1[col_eff] <= DIN;
      lb2[col_eff] <= tap1;
    end
  end

  // Counters, window shift registers and window-valid pulse
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      col       <= '0;
      row       <= 2'd0;
      D00       <= '0;
      D01       <= '0;
      D02       <= '0;
      D10       <= '0;
      D11       <= '0;
      D12       <= '0;
      D20       <= '0;
      D21       <= '0;
      D22       <= '0;
      WIN_VALID <= 1'b0;
    end else if (accept) begin
      col       <= col_nxt;
      row       <= row_nxt;
      D20       <= DIN;
      D21       <= D20;
      D22       <= D21;
      D10       <= tap1;
      D11       <= D10;
      D12       <= D11;
      D00       <= tap2;
      D01       <= D00;
      D02       <= D01;
      WIN_VALID <= (row_eff == 2'd2) && (col_eff >= CW'(2));
    end else begin
      WIN_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Testbench for window_gen_3x3: directed frame scenarios plus a random stream,
// all checked every cycle against an image-array reference model.
module tb_window_gen_3x3;

  localparam int W  = 4;
  localparam int PW = 24;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [PW-1:0] DIN = '0;
  logic          DIN_VALID = 1'b0;
  logic          DIN_SOF = 1'b0;
  logic [PW-1:0] D02, D01, D00, D12, D11, D10, D22, D21, D20;
  logic          WIN_VALID;

  window_gen_3x3 #(.IMG_WIDTH(W), .PIX_W(PW)) dut (
    .CLK(CLK), .RESET(RESET), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_SOF(DIN_SOF),
    .D02(D02), .D01(D01), .D00(D00), .D12(D12), .D11(D11), .D10(D10),
    .D22(D22), .D21(D21), .D20(D20), .WIN_VALID(WIN_VALID)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: image stored by absolute row (ring of 64 rows)
  logic [PW-1:0] img [64][W];
  int            m_r = 0, m_c = 0;
  logic          exp_valid = 1'b0;
  logic          d_known = 1'b0;
  logic [PW-1:0] exp_d [3][3];   // exp_d[line][tap], line 0 = r-2, tap 0 = column c

  always @(posedge CLK) begin
    if (!RESET) begin
      m_r = 0; m_c = 0;
      exp_valid = 1'b0;
      d_known = 1'b1;
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) exp_d[i][j] = '0;
    end else if (DIN_VALID) begin
      if (DIN_SOF) begin m_r = 0; m_c = 0; end
      img[m_r & 63][m_c] = DIN;
      if (m_r >= 2 && m_c >= 2) begin
        exp_valid = 1'b1;
        d_known = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_d[i][j] = img[(m_r - 2 + i) & 63][m_c - j];
      end else begin
        exp_valid = 1'b0;
        d_known = 1'b0;
      end
      m_c++;
      if (m_c == W) begin m_c = 0; m_r++; end
    end else begin
      exp_valid = 1'b0;
    end
  end

  // Single compare process: every cycle against the model
  always @(negedge CLK) begin
    check("win_valid", 32'(WIN_VALID), 32'(exp_valid));
    if (d_known) begin
      check("d00", 32'(D00), 32'(exp_d[0][0]));
      check("d01", 32'(D01), 32'(exp_d[0][1]));
      check("d02", 32'(D02), 32'(exp_d[0][2]));
      check("d10", 32'(D10), 32'(exp_d[1][0]));
      check("d11", 32'(D11), 32'(exp_d[1][1]));
      check("d12", 32'(D12), 32'(exp_d[1][2]));
      check("d20", 32'(D20), 32'(exp_d[2][0]));
      check("d21", 32'(D21), 32'(exp_d[2][1]));
      check("d22", 32'(D22), 32'(exp_d[2][2]));
    end
  end

  int pulses;

  // One clock: drive at negedge, return at the next negedge
  task automatic cyc(input logic v, input logic s, input logic [PW-1:0] d, input logic rst);
    DIN_VALID = v; DIN_SOF = s; DIN = d; RESET = rst;
    @(negedge CLK);
    if (WIN_VALID) pulses++;
  endtask

  task automatic px(input int base, input int r, input int c, input logic sof);
    cyc(1'b1, sof, PW'(base + 16 * r + c), 1'b1);
  endtask

  // Hand-computed window after accepting P(2,2) of a frame with given base
  task automatic check_p22(input string tag, input int base);
    check({tag, "_wv"},  32'(WIN_VALID), 32'd1);
    check({tag, "_d22"}, 32'(D22), 32'(base + 'h20));
    check({tag, "_d21"}, 32'(D21), 32'(base + 'h21));
    check({tag, "_d20"}, 32'(D20), 32'(base + 'h22));
    check({tag, "_d12"}, 32'(D12), 32'(base + 'h10));
    check({tag, "_d11"}, 32'(D11), 32'(base + 'h11));
    check({tag, "_d10"}, 32'(D10), 32'(base + 'h12));
    check({tag, "_d02"}, 32'(D02), 32'(base + 'h00));
    check({tag, "_d01"}, 32'(D01), 32'(base + 'h01));
    check({tag, "_d00"}, 32'(D00), 32'(base + 'h02));
  endtask

  task automatic send_frame(input string tag, input int base, input logic gap);
    logic prev_wv;
    prev_wv = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        px(base, r, c, (r == 0 && c == 0));
        if (r < 2 || c < 2) check({tag, "_border_wv"}, 32'(WIN_VALID), 32'd0);
        if (r == 2 && c == 2) check_p22(tag, base);
        if (gap) begin
          prev_wv = WIN_VALID;
          cyc(1'b0, 1'b0, PW'($urandom), 1'b1);
          if (prev_wv && WIN_VALID) check({tag, "_back2back"}, 32'd1, 32'd0);
        end
      end
  endtask

  initial begin
    @(negedge CLK);
    cyc(1'b1, 1'b1, 24'h123456, 1'b0);
    cyc(1'b0, 1'b0, 24'h0, 1'b0);
    check("reset_d11", 32'(D11), 32'd0);
    check("reset_wv", 32'(WIN_VALID), 32'd0);

    // Continuous frame
    pulses = 0;
    send_frame("cont", 0, 1'b0);
    check("cont_pulses", 32'(pulses), 32'd4);

    // Same frame with alternating valid
    pulses = 0;
    send_frame("gap", 0, 1'b1);
    check("gap_pulses", 32'(pulses), 32'd4);

    // Back-to-back second frame with distinct data
    pulses = 0;
    send_frame("f2", 'h100, 1'b0);
    check("f2_pulses", 32'(pulses), 32'd4);

    // SOF at (2,1): old frame abandoned, new frame starts there
    pulses = 0;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) px('h200, r, c, (r == 0 && c == 0));
    px('h200, 2, 0, 1'b0);
    check("midsof_pre", 32'(pulses), 32'd0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        px('h300, r, c, (r == 0 && c == 0));
        if (r == 2 && c == 1) check("midsof_before22", 32'(pulses), 32'd0);
        if (r == 2 && c == 2) check_p22("midsof", 'h300);
      end
    check("midsof_pulses", 32'(pulses), 32'd4);

    // Reset after P(3,2), then pixels without SOF
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (r < 3 || c <= 2) px('h400, r, c, (r == 0 && c == 0));
    cyc(1'b1, 1'b0, 24'h777777, 1'b0);
    check("rst_mid_d20", 32'(D20), 32'd0);
    check("rst_mid_d00", 32'(D00), 32'd0);
    check("rst_mid_wv", 32'(WIN_VALID), 32'd0);
    for (int i = 1; i <= 11; i++) begin
      cyc(1'b1, 1'b0, PW'('h500 + i), 1'b1);
      check("rst_11th", 32'(WIN_VALID), 32'(i == 11));
    end
    check("rst_11th_d20", 32'(D20), 32'h50b);
    check("rst_11th_d00", 32'(D00), 32'h503);

    // Random stream
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0), PW'($urandom),
          ($urandom_range(0, 299) != 0));
    end
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 Parameter IMG_WIDTH, default 640: active pixels per line. Legal range is 4..4096.
REQ-002 Parameter PIX_W, default 24: pixel width in bits, packed {R[23:16],G[15:8],B[7:0]}.
REQ-003 CLK  input  1: clock; all logic is rising-edge.
REQ-004 RESET  input  1: reset, synchronous, active-low.
REQ-005 DIN  input  PIX_W: input pixel in raster order.
REQ-006 DIN_VALID  input  1: DIN is accepted on a rising edge where this input is high.
REQ-007 DIN_SOF  input  1: first pixel of a frame; qualified by DIN_VALID.
REQ-008 D02,D01,D00  output  PIX_W each: upper window line, oldest line (row r-2).
REQ-009 D12,D11,D10  output  PIX_W each: middle window line (row r-1).
REQ-010 D22,D21,D20  output  PIX_W each: under window line, current line (row r).
REQ-011 Column index in all window outputs: x0 = column c, x1 = c-1, x2 = c-2. D11 is the window centre pixel (r-1, c-1).
REQ-012 WIN_VALID  output  1: one-cycle pulse marking a complete 3x3 window on the D outputs.

Function
REQ-013 The block shall contain two line buffers, each IMG_WIDTH x PIX_W, holding rows r-1 and r-2. Inferred RAM or registers are both permitted.
REQ-014 The block shall contain a 3-tap horizontal shift per window line.
REQ-015 The column counter (0..IMG_WIDTH-1) shall advance only on an accepted pixel and wrap to 0 after IMG_WIDTH-1.
REQ-016 The row counter shall increment on each column wrap and saturate at 2; only row >= 2 matters.
REQ-017 An accepted pixel with DIN_SOF=1 shall be treated as (row 0, col 0), overriding the counters on the same edge.
REQ-018 Window register update, on the edge after accepting P(r,c):
- D20=P(r,c), D21=P(r,c-1), D22=P(r,c-2)
- D10=P(r-1,c), D11=P(r-1,c-1), D12=P(r-1,c-2)
- D00=P(r-2,c), D01=P(r-2,c-1), D02=P(r-2,c-2)
REQ-019 Latency shall be exactly 1 cycle from the accepting edge to the D outputs and WIN_VALID.
REQ-020 WIN_VALID shall be 1 in the cycle after accepting P(r,c) iff row >= 2 and col >= 2; otherwise it shall be 0.
REQ-021 Window count per frame shall be (H-2)*(IMG_WIDTH-2), with no border padding.
REQ-022 When DIN_VALID=0, all D outputs shall hold their values, WIN_VALID shall be 0, and the counters and line buffers shall be unchanged.
REQ-023 Gaps of any length between accepted pixels, including across line ends, shall not alter the output sequence.
REQ-024 At col 0 and col 1, the x1/x2 taps contain pixels from the previous line. Their D values are don't-care; WIN_VALID shall be 0.
REQ-025 DIN_SOF mid-line shall abandon the partial line. Rows 0 and 1 of the new frame shall produce no WIN_VALID, regardless of stale line-buffer data.
REQ-026 DIN_SOF with DIN_VALID=0 shall be ignored.
REQ-027 Pixel data shall pass unmodified. There shall be no arithmetic on pixel values.

Reset
REQ-028 While RESET=0 on an edge, all D outputs shall be 0, WIN_VALID shall be 0, column=0 and row=0.
REQ-029 DIN_VALID shall be ignored during reset.
REQ-030 Line-buffer contents need not be cleared; no output shall depend on them before refill.
REQ-031 Reset mid-frame shall behave as a fresh start. The next accepted pixel is treated as row 0, col 0 even without DIN_SOF.

Verification
Tests use IMG_WIDTH=4 and pixel value P(r,c) = 16*r + c.
REQ-032 Continuous 4x4 frame with SOF on the first pixel -> exactly 4 WIN_VALID pulses, one cycle after accepting P(2,2), P(2,3), P(3,2), P(3,3). At P(2,2): D22..D20 = 0x20,0x21,0x22; D12..D10 = 0x10,0x11,0x12; D02..D00 = 0x00,0x01,0x02.
REQ-033 Same frame with DIN_VALID toggled 1-0-1-0 -> identical window values and pulse count. D outputs hold during gaps; WIN_VALID is never high two consecutive cycles.
REQ-034 Second frame with SOF immediately after the first -> no WIN_VALID for new-frame rows 0 and 1. The first pulse follows new P(2,2) and shows only new-frame data.
REQ-035 SOF asserted at (row 2, col 1) of a frame -> counters restart and no WIN_VALID occurs until new P(2,2).
REQ-036 RESET=0 for one cycle after accepting P(3,2) -> all outputs read 0 the next cycle; subsequent pixels are indexed from (0,0); the first pulse follows the 11th accepted pixel.
REQ-037 Boundary case IMG_WIDTH=4: column wrap 3->0 increments the row, and windows at col 0/1 never assert WIN_VALID.
